// File: rtl/calc_pkg.sv
// Shared calculator display definitions: active-low seven-segment glyphs,
// the all-anodes-off pattern and the scan digit index type.
package calc_pkg;

    // Glyph bit order is {g,f,e,d,c,b,a}, 0 = segment lit
    localparam logic [6:0] SEG_0    = 7'b1000000;
    localparam logic [6:0] SEG_1    = 7'b1111001;
    localparam logic [6:0] SEG_2    = 7'b0100100;
    localparam logic [6:0] SEG_3    = 7'b0110000;
    localparam logic [6:0] SEG_4    = 7'b0011001;
    localparam logic [6:0] SEG_5    = 7'b0010010;
    localparam logic [6:0] SEG_6    = 7'b0000010;
    localparam logic [6:0] SEG_7    = 7'b1111000;
    localparam logic [6:0] SEG_8    = 7'b0000000;
    localparam logic [6:0] SEG_9    = 7'b0010000;
    localparam logic [6:0] SEG_DASH = 7'b0111111;
    localparam logic [6:0] SEG_OFF  = 7'b1111111;

    localparam logic [3:0] AN_OFF   = 4'b1111;

    typedef logic [1:0] digit_idx_t;

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD nibble to active-low seven-segment glyph.
// Non-BCD nibbles (10-15) render as a dash so bad data is visible.
module bcd_to_seg7
    import calc_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_DASH;
        case (nib)
            4'd0: seg = SEG_0;
            4'd1: seg = SEG_1;
            4'd2: seg = SEG_2;
            4'd3: seg = SEG_3;
            4'd4: seg = SEG_4;
            4'd5: seg = SEG_5;
            4'd6: seg = SEG_6;
            4'd7: seg = SEG_7;
            4'd8: seg = SEG_8;
            4'd9: seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/seg7_scan.sv
// Four-digit common-anode display scanner with per-frame digit snapshot,
// optional leading-zero blanking and a one-cycle anode dead time per slot.
module seg7_scan
    import calc_pkg::*;
#(
    parameter int REFRESH_DIV = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] thousands,
    input  logic [3:0] hundreds,
    input  logic [3:0] tens,
    input  logic [3:0] ones,
    input  logic       blank_lz,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic       frame
);

    localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);

    logic [CW-1:0]     cnt_q, cnt_d;
    digit_idx_t        idx_q, idx_d;
    logic [3:0][3:0]   sh_q, sh_d;
    logic [3:0]        an_q, an_d;
    logic [6:0]        seg_q, seg_d;
    logic              frame_q, frame_d;
    logic              lit_q, lit_d;
    logic              tick, wrap, blank;
    logic [3:0]        nib;
    logic [6:0]        glyph;

    // Decode the digit that will be current after this edge, so on a wrap
    // seg already reflects the value being captured.
    bcd_to_seg7 u_dec (
        .nib (nib),
        .seg (glyph)
    );

    always_comb begin
        tick  = (cnt_q == CNT_MAX);
        cnt_d = tick ? '0 : cnt_q + 1'b1;
        idx_d = tick ? idx_q + 2'd1 : idx_q;
        wrap  = tick && (idx_q == 2'd3);
        sh_d  = wrap ? {thousands, hundreds, tens, ones} : sh_q;
        nib   = sh_d[idx_d];

        // Non-BCD nibbles are nonzero, so they stop blanking naturally
        blank = 1'b0;
        case (idx_q)
            2'd3: blank = (sh_q[3] == 4'd0);
            2'd2: blank = (sh_q[3] == 4'd0) && (sh_q[2] == 4'd0);
            2'd1: blank = (sh_q[3] == 4'd0) && (sh_q[2] == 4'd0) && (sh_q[1] == 4'd0);
            default: blank = 1'b0;
        endcase
        blank = blank && blank_lz;

        lit_d   = tick;
        seg_d   = tick ? glyph : seg_q;
        frame_d = wrap;
        an_d    = an_q;
        if (tick)
            an_d = AN_OFF;
        else if (lit_q)
            an_d = blank ? AN_OFF : ~(4'b0001 << idx_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            idx_q   <= 2'd3;
            sh_q    <= '0;
            an_q    <= AN_OFF;
            seg_q   <= SEG_OFF;
            frame_q <= 1'b0;
            lit_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            sh_q    <= sh_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
            frame_q <= frame_d;
            lit_q   <= lit_d;
        end
    end

    assign an    = an_q;
    assign seg   = seg_q;
    assign dp    = 1'b1;
    assign frame = frame_q;

endmodule

// File: tb/tb_seg7_scan.sv
// Scoreboard bench for seg7_scan at REFRESH_DIV = 4: each frame's expected
// per-slot glyph/anode/frame values are queued when inputs are set.
module tb_seg7_scan;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] thousands = 4'd0, hundreds = 4'd0, tens = 4'd0, ones = 4'd0;
    logic       blank_lz = 1'b0;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       frame;

    int n_chk = 0;
    int n_err = 0;

    typedef struct {
        logic [6:0] seg;
        logic [3:0] an;
        logic       frame;
    } exp_t;

    exp_t sb[$];

    seg7_scan #(.REFRESH_DIV(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .thousands (thousands),
        .hundreds  (hundreds),
        .tens      (tens),
        .ones      (ones),
        .blank_lz  (blank_lz),
        .an        (an),
        .seg       (seg),
        .dp        (dp),
        .frame     (frame)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] ref_glyph(input logic [3:0] n);
        case (n)
            4'd0: return 7'b1000000;
            4'd1: return 7'b1111001;
            4'd2: return 7'b0100100;
            4'd3: return 7'b0110000;
            4'd4: return 7'b0011001;
            4'd5: return 7'b0010010;
            4'd6: return 7'b0000010;
            4'd7: return 7'b1111000;
            4'd8: return 7'b0000000;
            4'd9: return 7'b0010000;
            default: return 7'b0111111;
        endcase
    endfunction

    task automatic set_in(input logic [3:0] d3, d2, d1, d0, input logic blz);
        thousands = d3; hundreds = d2; tens = d1; ones = d0; blank_lz = blz;
    endtask

    // Queue a frame's four slots in scan order: ones, tens, hundreds, thousands
    task automatic push_frame(input logic [3:0] d3, d2, d1, d0, input logic blz);
        exp_t e;
        logic b3, b2, b1;
        b3 = blz && (d3 == 4'd0);
        b2 = b3 && (d2 == 4'd0);
        b1 = b2 && (d1 == 4'd0);
        e.seg = ref_glyph(d0); e.an = 4'b1110;               e.frame = 1'b1; sb.push_back(e);
        e.seg = ref_glyph(d1); e.an = b1 ? 4'b1111 : 4'b1101; e.frame = 1'b0; sb.push_back(e);
        e.seg = ref_glyph(d2); e.an = b2 ? 4'b1111 : 4'b1011; e.frame = 1'b0; sb.push_back(e);
        e.seg = ref_glyph(d3); e.an = b3 ? 4'b1111 : 4'b0111; e.frame = 1'b0; sb.push_back(e);
    endtask

    // Assumes the next rising edge is a tick edge
    task automatic check_slot(input string nm);
        exp_t e;
        if (sb.size() == 0) begin
            n_chk++; n_err++;
            $display("FAIL %s: scoreboard empty", nm);
            return;
        end
        e = sb.pop_front();
        @(posedge clk); #1;
        n_chk++; if (seg !== e.seg) begin n_err++; $display("FAIL %s seg@tick: got %b want %b", nm, seg, e.seg); end
        n_chk++; if (an !== 4'b1111) begin n_err++; $display("FAIL %s an dead: got %b want 1111", nm, an); end
        n_chk++; if (frame !== e.frame) begin n_err++; $display("FAIL %s frame: got %b want %b", nm, frame, e.frame); end
        @(posedge clk); #1;
        n_chk++; if (an !== e.an) begin n_err++; $display("FAIL %s an lit: got %b want %b", nm, an, e.an); end
        n_chk++; if (frame !== 1'b0) begin n_err++; $display("FAIL %s frame pulse: got %b want 0", nm, frame); end
        repeat (2) @(posedge clk);
        #1;
        n_chk++; if (an !== e.an || seg !== e.seg) begin
            n_err++; $display("FAIL %s hold: got an=%b seg=%b want an=%b seg=%b", nm, an, seg, e.an, e.seg);
        end
    endtask

    task automatic check_dark(input string nm);
        n_chk++;
        if (an !== 4'b1111 || seg !== 7'b1111111 || frame !== 1'b0 || dp !== 1'b1) begin
            n_err++;
            $display("FAIL %s: got an=%b seg=%b frame=%b dp=%b want 1111/1111111/0/1", nm, an, seg, frame, dp);
        end
    endtask

    task automatic test_reset();
        set_in(4'd9, 4'd8, 4'd0, 4'd1, 1'b0);
        push_frame(4'd9, 4'd8, 4'd0, 4'd1, 1'b0);
        rst = 1'b1;
        #1 check_dark("reset_async");
        repeat (3) @(posedge clk);
        #1 check_dark("reset_held");
        @(negedge clk);
        rst = 1'b0;
        #1 check_dark("reset_release");
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check_dark("reset_pre_tick");
        end
        check_slot("reset_first_tick");
    endtask

    task automatic test_scan_9801();
        check_slot("9801_tens");
        check_slot("9801_hundreds");
        check_slot("9801_thousands");
    endtask

    task automatic test_blanking();
        set_in(4'd0, 4'd0, 4'd4, 4'd2, 1'b1);
        push_frame(4'd0, 4'd0, 4'd4, 4'd2, 1'b1);
        for (int i = 0; i < 4; i++) check_slot("blank_0042");
        set_in(4'd0, 4'd0, 4'd0, 4'd0, 1'b1);
        push_frame(4'd0, 4'd0, 4'd0, 4'd0, 1'b1);
        for (int i = 0; i < 4; i++) check_slot("blank_0000");
    endtask

    task automatic test_coherence();
        set_in(4'd9, 4'd8, 4'd0, 4'd1, 1'b0);
        push_frame(4'd9, 4'd8, 4'd0, 4'd1, 1'b0);
        check_slot("coh_ones");
        check_slot("coh_tens");
        // Still inside the tens slot here
        set_in(4'd1, 4'd2, 4'd3, 4'd4, 1'b0);
        push_frame(4'd1, 4'd2, 4'd3, 4'd4, 1'b0);
        check_slot("coh_old_hundreds");
        check_slot("coh_old_thousands");
        for (int i = 0; i < 4; i++) check_slot("coh_new_frame");
    endtask

    task automatic test_invalid();
        set_in(4'd0, 4'd0, 4'hA, 4'd5, 1'b1);
        push_frame(4'd0, 4'd0, 4'hA, 4'd5, 1'b1);
        for (int i = 0; i < 4; i++) check_slot("invalid_nibble");
    endtask

    task automatic test_async_reset();
        exp_t e;
        set_in(4'd9, 4'd8, 4'd0, 4'd1, 1'b0);
        push_frame(4'd9, 4'd8, 4'd0, 4'd1, 1'b0);
        check_slot("arst_ones");
        check_slot("arst_tens");
        e = sb.pop_front();
        @(posedge clk); @(posedge clk); #1;
        n_chk++; if (an !== e.an) begin n_err++; $display("FAIL arst_pre_an: got %b want %b", an, e.an); end
        #2 rst = 1'b1;
        #1 check_dark("arst_immediate");
        #1 rst = 1'b0;
        void'(sb.pop_front());
        push_frame(4'd9, 4'd8, 4'd0, 4'd1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check_dark("arst_pre_tick");
        end
        for (int i = 0; i < 4; i++) check_slot("arst_restart");
    endtask

    initial begin
        test_reset();
        test_scan_9801();
        test_blanking();
        test_coherence();
        test_invalid();
        test_async_reset();
        n_chk++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: got %0d left want 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
